dac_update_sched: RTL and testbench

- Multi-requester update scheduler for the 32-bit SPI DAC link.
- Up to NCH channel producers each present a 12-bit sample with a req/ack handshake; one broadcast requester writes all DAC channels at once.
- The block arbitrates between them (broadcast first, then round-robin), builds the write-and-update frame for the granted channel and serialises it on cs/sck/mosi.
- It is the only driver of the DAC pins and sits between the waveform or control logic and the board-level DAC.

---
 rtl/dac_update_sched.sv | 181 ++++++++++++++++++
 tb/tb_dac_update_sched.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_update_sched.sv
// Update scheduler for the 32-bit SPI DAC link: arbitrates broadcast and
// per-channel sample requests, then serialises one write-and-update frame.
module dac_update_sched #(
  parameter int unsigned NCH  = 4,
  parameter int unsigned CDIV = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH-1:0]    req,
  input  logic [NCH*12-1:0] data,
  output logic [NCH-1:0]    ack,
  input  logic              bcast_req,
  input  logic [11:0]       bcast_data,
  output logic              bcast_ack,
  output logic              busy,
  output logic              cs,
  output logic              sck,
  output logic              mosi,
  output logic              clr
);

  localparam int unsigned PW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int unsigned TW = (CDIV > 1) ? $clog2(CDIV) : 1;
  localparam int unsigned SW = 12;
  localparam int unsigned FW = 32;
  localparam int unsigned BW = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2,
    HOLD  = 2'd3
  } state_e;

  state_e         state_q, state_d;
  logic [PW-1:0]  rr_q, rr_d;
  logic [TW-1:0]  tick_q, tick_d;
  logic [BW-1:0]  bit_cnt_q, bit_cnt_d;
  logic [FW-1:0]  frame_q, frame_d;
  logic [NCH-1:0] ack_q, ack_d;
  logic           bcast_ack_q, bcast_ack_d;
  logic           busy_q, busy_d;
  logic           cs_q, cs_d;
  logic           sck_q, sck_d;
  logic           mosi_q, mosi_d;
  logic           clr_q, clr_d;

  logic           win_found_c;
  logic [PW-1:0]  win_idx_c;
  logic [PW-1:0]  cand_c;
  logic           tick_hit_c;

  // Round-robin search starting just after the last granted channel.
  always_comb begin
    win_found_c = 1'b0;
    win_idx_c   = '0;
    cand_c      = '0;
    for (int unsigned k = 1; k <= NCH; k++) begin
      cand_c = PW'((int'(rr_q) + int'(k)) % int'(NCH));
      if (!win_found_c && req[cand_c]) begin
        win_found_c = 1'b1;
        win_idx_c   = cand_c;
      end
    end
  end

  assign tick_hit_c = (tick_q == TW'(CDIV - 1));

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    tick_d      = tick_q;
    bit_cnt_d   = bit_cnt_q;
    frame_d     = frame_q;
    ack_d       = '0;
    bcast_ack_d = 1'b0;
    cs_d        = cs_q;
    sck_d       = sck_q;
    mosi_d      = mosi_q;
    clr_d       = 1'b1;

    case (state_q)
      IDLE: begin
        if (bcast_req || win_found_c) begin
          if (bcast_req) begin
            frame_d     = {8'h00, 4'b0011, 4'hF, bcast_data, 4'h0};
            bcast_ack_d = 1'b1;
          end else begin
            frame_d          = {8'h00, 4'b0011, 4'(win_idx_c),
                                data[SW*win_idx_c +: SW], 4'h0};
            ack_d[win_idx_c] = 1'b1;
            rr_d             = win_idx_c;
          end
          cs_d      = 1'b0;
          sck_d     = 1'b0;
          mosi_d    = frame_d[FW-1];
          tick_d    = '0;
          bit_cnt_d = '0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        tick_d = tick_hit_c ? '0 : tick_q + TW'(1);
        if (tick_hit_c) begin
          if (!sck_q) begin
            sck_d = 1'b1;
          end else begin
            sck_d     = 1'b0;
            bit_cnt_d = bit_cnt_q + BW'(1);
            if (bit_cnt_q == BW'(FW - 1)) begin
              state_d = GAP;
            end else begin
              frame_d = {frame_q[FW-2:0], 1'b0};
              mosi_d  = frame_q[FW-2];
            end
          end
        end
      end
      GAP: begin
        tick_d = tick_hit_c ? '0 : tick_q + TW'(1);
        if (tick_hit_c) begin
          cs_d    = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        tick_d = tick_hit_c ? '0 : tick_q + TW'(1);
        if (tick_hit_c) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cs_d    = 1'b1;
        sck_d   = 1'b0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_q        <= PW'(NCH - 1);
      tick_q      <= '0;
      bit_cnt_q   <= '0;
      frame_q     <= '0;
      ack_q       <= '0;
      bcast_ack_q <= 1'b0;
      busy_q      <= 1'b0;
      cs_q        <= 1'b1;
      sck_q       <= 1'b0;
      mosi_q      <= 1'b0;
      clr_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      tick_q      <= tick_d;
      bit_cnt_q   <= bit_cnt_d;
      frame_q     <= frame_d;
      ack_q       <= ack_d;
      bcast_ack_q <= bcast_ack_d;
      busy_q      <= busy_d;
      cs_q        <= cs_d;
      sck_q       <= sck_d;
      mosi_q      <= mosi_d;
      clr_q       <= clr_d;
    end
  end

  assign ack       = ack_q;
  assign bcast_ack = bcast_ack_q;
  assign busy      = busy_q;
  assign cs        = cs_q;
  assign sck       = sck_q;
  assign mosi      = mosi_q;
  assign clr       = clr_q;

endmodule

// File: tb/tb_dac_update_sched.sv
// Directed bench for dac_update_sched: CDIV=2 and CDIV=1 instances, NCH=4,
// with a pin-level monitor that decodes frames from cs/sck/mosi.
module tb_dac_update_sched;

  localparam int NCH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst0, rst1, sel;
  logic [NCH-1:0]    req0, req1, ack0, ack1;
  logic [NCH*12-1:0] data0, data1;
  logic              bcast_req0, bcast_req1, bcast_ack0, bcast_ack1;
  logic [11:0]       bcast_data0, bcast_data1;
  logic              busy0, busy1, cs0, cs1, sck0, sck1, mosi0, mosi1, clr0, clr1;

  dac_update_sched #(.NCH(NCH), .CDIV(2)) u_dut0 (
    .clk(clk), .rst(rst0), .req(req0), .data(data0), .ack(ack0),
    .bcast_req(bcast_req0), .bcast_data(bcast_data0), .bcast_ack(bcast_ack0),
    .busy(busy0), .cs(cs0), .sck(sck0), .mosi(mosi0), .clr(clr0)
  );

  dac_update_sched #(.NCH(NCH), .CDIV(1)) u_dut1 (
    .clk(clk), .rst(rst1), .req(req1), .data(data1), .ack(ack1),
    .bcast_req(bcast_req1), .bcast_data(bcast_data1), .bcast_ack(bcast_ack1),
    .busy(busy1), .cs(cs1), .sck(sck1), .mosi(mosi1), .clr(clr1)
  );

  // Monitor observes whichever instance is selected.
  logic           m_rst, m_cs, m_sck, m_mosi, m_back;
  logic [NCH-1:0] m_ack;
  assign m_rst  = sel ? rst1 : rst0;
  assign m_cs   = sel ? cs1 : cs0;
  assign m_sck  = sel ? sck1 : sck0;
  assign m_mosi = sel ? mosi1 : mosi0;
  assign m_back = sel ? bcast_ack1 : bcast_ack0;
  assign m_ack  = sel ? ack1 : ack0;

  int          cyc = 0;
  logic        p_cs = 1'b1, p_sck = 1'b0, p_mosi = 1'b0, p_any = 1'b0;
  logic [31:0] shreg = '0;
  int          nbit = 0, low_len = 0;
  logic [31:0] frames[$];
  int          fbits[$], flen[$], cs_fall[$], ack_log[$];
  int          edge_sck_bad = 0, ack_multi = 0, mosi_bad = 0, run_bad = 0;

  int n_err = 0;
  int n_chk = 0;

  function automatic int enc(input logic [NCH-1:0] a);
    case (a)
      4'b0001: return 0;
      4'b0010: return 1;
      4'b0100: return 2;
      4'b1000: return 3;
      default: return 99;
    endcase
  endfunction

  always @(negedge clk) begin
    cyc++;
    if (m_rst) begin
      p_cs = 1'b1; p_sck = 1'b0; p_mosi = 1'b0; p_any = 1'b0;
      nbit = 0; shreg = '0;
    end else begin
      if (p_cs && !m_cs) begin
        cs_fall.push_back(cyc);
        nbit = 0; low_len = 0; shreg = '0;
        if (m_sck) edge_sck_bad++;
      end
      if (!m_cs) low_len++;
      if (!m_cs && !p_cs && (m_sck == p_sck)) run_bad++;
      if (!p_sck && m_sck) begin
        shreg = {shreg[30:0], m_mosi};
        nbit++;
      end
      if (p_sck && m_sck && (m_mosi != p_mosi)) mosi_bad++;
      if (!p_cs && m_cs) begin
        frames.push_back(shreg);
        fbits.push_back(nbit);
        flen.push_back(low_len);
        if (m_sck) edge_sck_bad++;
      end
      if (m_back) ack_log.push_back(15);
      else if (m_ack != '0) ack_log.push_back(enc(m_ack));
      if ((m_back || (m_ack != '0)) && p_any) ack_multi++;
      p_cs = m_cs; p_sck = m_sck; p_mosi = m_mosi;
      p_any = m_back || (m_ack != '0);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_log();
    frames.delete(); fbits.delete(); flen.delete(); cs_fall.delete(); ack_log.delete();
    edge_sck_bad = 0; ack_multi = 0; mosi_bad = 0; run_bad = 0;
  endtask

  task automatic wait_frames(input int n, input int budget);
    int i;
    i = 0;
    while (frames.size() < n && i < budget) begin tick(); i++; end
    check("frames_arrive", 32'(frames.size() >= n), 32'd1);
  endtask

  task automatic wait_ack0(input int budget);
    int i;
    i = 0;
    while (ack0 == '0 && i < budget) begin tick(); i++; end
  endtask

  task automatic wait_idle0(input int budget);
    int i;
    i = 0;
    while (busy0 && i < budget) begin tick(); i++; end
    check("idle_reached", 32'(busy0), 32'd0);
  endtask

  function automatic logic [31:0] chan_frame(input int ch, input logic [11:0] v);
    return {8'h00, 4'b0011, 4'(ch), v, 4'h0};
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a_cyc, i;
    sel = 1'b0; rst0 = 1'b1; rst1 = 1'b1;
    req0 = '0; req1 = '0; data0 = '0; data1 = '0;
    bcast_req0 = 1'b0; bcast_req1 = 1'b0; bcast_data0 = '0; bcast_data1 = '0;
    repeat (3) tick();

    // Reset state.
    check("rst_cs", 32'(cs0), 32'd1);
    check("rst_sck", 32'(sck0), 32'd0);
    check("rst_mosi", 32'(mosi0), 32'd0);
    check("rst_clr", 32'(clr0), 32'd0);
    check("rst_ack", 32'(ack0), 32'd0);
    check("rst_bcast_ack", 32'(bcast_ack0), 32'd0);
    check("rst_busy", 32'(busy0), 32'd0);
    rst0 = 1'b0; rst1 = 1'b0;
    check("clr_before_edge", 32'(clr0), 32'd0);
    tick();
    check("clr_after_edge", 32'(clr0), 32'd1);
    check("clr1_after_edge", 32'(clr1), 32'd1);

    // Single channel 2 frame.
    clear_log();
    data0[2*12 +: 12] = 12'hABC;
    req0 = 4'b0100;
    wait_ack0(20);
    check("t1_ack", 32'(ack0), 32'h4);
    req0 = '0;
    a_cyc = cyc;
    tick();
    check("t1_ack_pulse", 32'(ack0), 32'd0);
    wait_frames(1, 300);
    check("t1_frame", frames[0], 32'h0032ABC0);
    check("t1_bits", 32'(fbits[0]), 32'd32);
    check("t1_cs_low", 32'(flen[0]), 32'd130);
    check("t1_cs_fall_at_ack", 32'(cs_fall[0]), 32'(a_cyc));
    check("t1_sck_at_cs_edges", 32'(edge_sck_bad), 32'd0);
    check("t1_mosi_stable", 32'(mosi_bad), 32'd0);
    wait_idle0(20);

    // Broadcast and channel 1 raised together: broadcast first.
    clear_log();
    data0[1*12 +: 12] = 12'h123;
    bcast_data0 = 12'h800;
    bcast_req0 = 1'b1;
    req0 = 4'b0010;
    i = 0;
    while (!bcast_ack0 && i < 20) begin tick(); i++; end
    check("t2_bcast_ack", 32'(bcast_ack0), 32'd1);
    check("t2_no_chan_ack", 32'(ack0), 32'd0);
    bcast_req0 = 1'b0;
    wait_ack0(300);
    check("t2_ack1", 32'(ack0), 32'h2);
    req0 = '0;
    wait_frames(2, 300);
    check("t2_bcast_frame", frames[0], 32'h003F8000);
    check("t2_ch1_frame", frames[1], chan_frame(1, 12'h123));
    check("t2_order0", 32'(ack_log[0]), 32'd15);
    check("t2_order1", 32'(ack_log[1]), 32'd1);
    wait_idle0(20);

    // Short req[3] pulse while busy is never served.
    clear_log();
    data0[0 +: 12] = 12'h111;
    req0 = 4'b0001;
    wait_ack0(20);
    req0 = '0;
    repeat (20) tick();
    req0 = 4'b1000;
    tick();
    req0 = '0;
    wait_idle0(300);
    repeat (10) tick();
    check("t5_acks", 32'(ack_log.size()), 32'd1);
    check("t5_frames", 32'(frames.size()), 32'd1);
    check("t5_frame0", frames[0], chan_frame(0, 12'h111));

    // Reset in the middle of a frame.
    clear_log();
    data0[2*12 +: 12] = 12'h5A5;
    req0 = 4'b0100;
    wait_ack0(20);
    req0 = '0;
    i = 0;
    while (nbit < 10 && i < 200) begin tick(); i++; end
    check("t4_bit10_reached", 32'(nbit), 32'd10);
    rst0 = 1'b1;
    #1;
    check("t4_cs_async", 32'(cs0), 32'd1);
    check("t4_sck_async", 32'(sck0), 32'd0);
    check("t4_clr_in_rst", 32'(clr0), 32'd0);
    check("t4_busy_in_rst", 32'(busy0), 32'd0);
    repeat (3) tick();
    check("t4_ack_in_rst", 32'(ack0), 32'd0);
    rst0 = 1'b0;
    tick();
    check("t4_clr_after", 32'(clr0), 32'd1);
    check("t4_no_partial_frame", 32'(frames.size()), 32'd0);

    // All four held from reset pointer: 0,1,2,3,0 at 133-cycle spacing.
    clear_log();
    data0 = {12'h444, 12'h333, 12'h222, 12'h111};
    req0 = 4'hF;
    i = 0;
    while (ack_log.size() < 5 && i < 1000) begin tick(); i++; end
    req0 = '0;
    wait_frames(5, 400);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("t3_grant%0d", k), 32'(ack_log[k]), 32'(k % 4));
      check($sformatf("t3_frame%0d", k), frames[k],
            chan_frame(k % 4, 12'(12'h111 * ((k % 4) + 1))));
    end
    for (int k = 1; k < 5; k++)
      check($sformatf("t3_period%0d", k), 32'(cs_fall[k] - cs_fall[k-1]), 32'd133);
    check("t3_ack_single", 32'(ack_multi), 32'd0);
    wait_idle0(20);

    // CDIV=1 instance, channel 1 held for two frames.
    sel = 1'b1;
    tick();
    clear_log();
    data1[1*12 +: 12] = 12'hFFF;
    req1 = 4'b0010;
    i = 0;
    while (ack_log.size() < 2 && i < 300) begin tick(); i++; end
    req1 = '0;
    wait_frames(2, 200);
    check("t6_frame0", frames[0], 32'h0031FFF0);
    check("t6_frame1", frames[1], 32'h0031FFF0);
    check("t6_bits", 32'(fbits[0]), 32'd32);
    check("t6_cs_low", 32'(flen[0]), 32'd65);
    check("t6_period", 32'(cs_fall[1] - cs_fall[0]), 32'd67);
    check("t6_sck_runs", 32'(run_bad), 32'd0);
    check("t6_sck_at_cs_edges", 32'(edge_sck_bad), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
